gate_checker: RTL and testbench
===============================

# gate_checker

Self-checking stimulus/response stage wrapped around the team's six two-input logic-gate modules. It drives a shared `a`/`b` input pair into the gates, sweeps all four input combinations, and samples the gate outputs one cycle later. Each sample is compared against an internal reference model, and the block reports per-gate failures and an error count through a start/busy/done handshake. It sits directly upstream of the gate instances, which it feeds, and directly downstream of their outputs, which it consumes.

## Interface
- `REPEAT`, default 1: number of full 4-vector sweeps per run (1..15).
- `CNT_W`, default 8: width of `err_count`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: run request; sampled only in IDLE or DONE.
- `gate_a` out 1: registered stimulus input A to all gates.
- `gate_b` out 1: registered stimulus input B to all gates.
- `gate_y` in 6: gate outputs. Bit0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR, 5 XNOR.
- `busy` out 1: high in DRIVE/SAMPLE.
- `done` out 1: high in DONE; held until next accepted `start`.
- `pass` out 1: valid when `done`; 1 iff `err_vec == 0`.
- `err_vec` out 6: sticky per-gate mismatch flags, same bit order as `gate_y`.
- `err_count` out CNT_W: total mismatching gate-samples, saturating.

## Operation
- States:
  - **IDLE**: `start` -> DRIVE. Vector counter, pass counter, `err_vec` and `err_count` are cleared.
  - **DRIVE**: `{gate_a,gate_b} <= vec`, then -> SAMPLE.
  - **SAMPLE**: compare `gate_y` against the reference model of the current `{gate_a,gate_b}`.
    - Update `err_vec |= mismatch`.
    - Add `popcount(mismatch)` to `err_count`, saturating at all-ones.
    - `vec` increments mod 4. On wrap from 3, the pass counter increments.
    - After the last vector of pass `REPEAT` -> DONE; otherwise -> DRIVE.
  - **DONE**: `start` -> DRIVE, clearing the counters and `err_vec`/`err_count` as in IDLE.
- Vector order is 00, 01, 10, 11, as `{a,b}`.
- `start` in DRIVE/SAMPLE is ignored, with no effect on the run.
- `gate_y` is assumed combinational from `gate_a`/`gate_b`; it is sampled exactly one cycle after the drive.
- Multiple mismatches in one sample add their full count. Saturation is checked against the post-add value.

## Timing
- Reset values:
  - state IDLE
  - `gate_a=0`, `gate_b=0`
  - `busy=0`, `done=0`, `pass=0`
  - `err_vec=0`, `err_count=0`
- Run cycle count: `start` high at edge T -> DRIVE during T+1, SAMPLE during T+2.
- Each vector takes 2 cycles. `done` rises at edge T+1+8·REPEAT (T+9 for REPEAT=1).
- `busy` is high from T+1 through the final SAMPLE cycle; `busy` and `done` are never high together.
- `pass` is registered with `done`. `err_vec`/`err_count` hold their final values throughout DONE.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronously), with no partial results retained.
- A `start` held high continuously in DONE restarts the run every 8·REPEAT+1 cycles.

## Structure
- Package `gate_pkg`:
  - gate index constants (`G_AND`=0 … `G_XNOR`=5, `N_GATES`=6)
  - state encoding (IDLE, DRIVE, SAMPLE, DONE)
  - vector width constant (2)
- Sub-module `gate_ref_model`: combinational; input `a`, `b`; output expected[5:0] in `gate_pkg` bit order. It is built independently of the gate modules under test.
- The top level holds the FSM, vector/pass counters, compare logic, popcount and the saturating accumulator.

## Test plan
- All six gates correct, REPEAT=1, `start` pulse -> `done` at T+9, `pass=1`, `err_vec=6'b000000`, `err_count=0`.
- XOR output stuck at 0 -> `err_vec=6'b010000`, `err_count=2` (vectors 01, 10), `pass=0`.
- NAND wired into the AND slot, others correct -> `err_vec=6'b000001`, `err_count=4`.
- REPEAT=2, XNOR stuck at 1 -> `done` at T+17, `err_vec=6'b100000`, `err_count=4`. `start` pulsed during `busy` changes nothing.
- `rst_n` low during pass 1, SAMPLE of vector 10 -> all outputs 0 the same cycle. The next `start` produces a clean full run.
- CNT_W=2, REPEAT=3, all six `gate_y` inverted -> `err_count` saturates at 3, `err_vec=6'b111111`, `done` at T+25.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared constants for the gate checker: gate bit order, FSM encoding and
// the stimulus vector width.
package gate_pkg;

    localparam int G_AND   = 0;
    localparam int G_OR    = 1;
    localparam int G_NOR   = 2;
    localparam int G_NAND  = 3;
    localparam int G_XOR   = 4;
    localparam int G_XNOR  = 5;
    localparam int N_GATES = 6;

    localparam int VEC_W = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic [2:0] popcount6(input logic [N_GATES-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < N_GATES; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Golden truth table for the six gates, written directly from the gate
// definitions so it shares nothing with the gate modules under test.
module gate_ref_model
    import gate_pkg::*;
(
    input  logic               a,
    input  logic               b,
    output logic [N_GATES-1:0] expected
);

    always_comb begin
        expected         = '0;
        expected[G_AND]  = a & b;
        expected[G_OR]   = a | b;
        expected[G_NOR]  = ~(a | b);
        expected[G_NAND] = ~(a & b);
        expected[G_XOR]  = a ^ b;
        expected[G_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_checker.sv
// Drives all four {a,b} combinations into the gates REPEAT times, checks
// the returned outputs against the reference model and accumulates errors.
module gate_checker
    import gate_pkg::*;
#(
    parameter int REPEAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               gate_a,
    output logic               gate_b,
    input  logic [N_GATES-1:0] gate_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_GATES-1:0] err_vec,
    output logic [CNT_W-1:0]   err_count
);

    // Handshake: start is accepted only in IDLE or DONE; busy covers the whole
    // run, done then holds pass/err_vec/err_count stable until the next start.
    logic [1:0]         state;
    logic [VEC_W-1:0]   vec;
    logic [3:0]         pass_cnt;
    logic               pass_q;
    logic [N_GATES-1:0] exp_y;
    logic [N_GATES-1:0] mismatch;
    logic [2:0]         mis_cnt;
    logic [CNT_W+2:0]   sum;
    logic [CNT_W-1:0]   next_count;
    logic               last_vec;

    gate_ref_model u_ref (
        .a        (gate_a),
        .b        (gate_b),
        .expected (exp_y)
    );

    assign mismatch = gate_y ^ exp_y;
    assign mis_cnt  = popcount6(mismatch);

    // Widened so the post-add value is seen before clamping to all-ones.
    assign sum        = {3'b000, err_count} + {{CNT_W{1'b0}}, mis_cnt};
    assign next_count = (sum[CNT_W+2:CNT_W] != 3'b000) ? {CNT_W{1'b1}}
                                                       : sum[CNT_W-1:0];

    assign last_vec = (vec == 2'd3) && (pass_cnt == 4'(REPEAT - 1));

    assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done = (state == S_DONE);
    assign pass = pass_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec       <= '0;
            pass_cnt  <= 4'd0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            pass_q    <= 1'b0;
            err_vec   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        vec       <= '0;
                        pass_cnt  <= 4'd0;
                        pass_q    <= 1'b0;
                        err_vec   <= '0;
                        err_count <= '0;
                    end
                end
                S_DRIVE: begin
                    gate_a <= vec[1];
                    gate_b <= vec[0];
                    state  <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    err_vec   <= err_vec | mismatch;
                    err_count <= next_count;
                    vec       <= vec + 2'd1;
                    if (vec == 2'd3) begin
                        pass_cnt <= pass_cnt + 4'd1;
                    end
                    if (last_vec) begin
                        state  <= S_DONE;
                        pass_q <= ((err_vec | mismatch) == '0);
                    end else begin
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances with different REPEAT/CNT_W, faulty
// gate models on gate_y, directed scenarios and random fault tables.
module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st [3];
    logic       ga [3];
    logic       gb [3];
    logic [5:0] gy [3];
    logic       bs [3];
    logic       dn [3];
    logic       ps [3];
    logic [5:0] ev [3];
    logic [7:0] ec [3];
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    int         mode_r [3];
    logic [5:0] tbl [3][4];
    int         rep [3]  = '{1, 2, 3};
    int         maxc [3] = '{255, 255, 3};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Gate behaviour from the input sum, then the selected fault applied.
    function automatic logic [5:0] truth(input logic a, input logic b);
        int s;
        logic [5:0] r;
        s = int'(a) + int'(b);
        r[0] = (s == 2);
        r[1] = (s >= 1);
        r[2] = (s == 0);
        r[3] = (s < 2);
        r[4] = (s == 1);
        r[5] = (s != 1);
        return r;
    endfunction

    function automatic logic [5:0] faulty_y(input int mode, input logic a, input logic b,
                                            input logic [5:0] flip);
        logic [5:0] t;
        t = truth(a, b);
        case (mode)
            1: t[4] = 1'b0;
            2: t[0] = ~(a & b);
            3: t[5] = 1'b1;
            4: t = ~t;
            5: t = t ^ flip;
            default: ;
        endcase
        return t;
    endfunction

    assign gy[0] = faulty_y(mode_r[0], ga[0], gb[0], tbl[0][{ga[0], gb[0]}]);
    assign gy[1] = faulty_y(mode_r[1], ga[1], gb[1], tbl[1][{ga[1], gb[1]}]);
    assign gy[2] = faulty_y(mode_r[2], ga[2], gb[2], tbl[2][{ga[2], gb[2]}]);
    assign ec[0] = ec0;
    assign ec[1] = ec1;
    assign ec[2] = {6'b000000, ec2};

    gate_checker #(.REPEAT(1), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .gate_a(ga[0]), .gate_b(gb[0]),
        .gate_y(gy[0]), .busy(bs[0]), .done(dn[0]), .pass(ps[0]),
        .err_vec(ev[0]), .err_count(ec0)
    );
    gate_checker #(.REPEAT(2), .CNT_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .gate_a(ga[1]), .gate_b(gb[1]),
        .gate_y(gy[1]), .busy(bs[1]), .done(dn[1]), .pass(ps[1]),
        .err_vec(ev[1]), .err_count(ec1)
    );
    gate_checker #(.REPEAT(3), .CNT_W(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .gate_a(ga[2]), .gate_b(gb[2]),
        .gate_y(gy[2]), .busy(bs[2]), .done(dn[2]), .pass(ps[2]),
        .err_vec(ev[2]), .err_count(ec2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check({tag, "_gate_a"}, ga[i], 0);
        check({tag, "_gate_b"}, gb[i], 0);
        check({tag, "_busy"}, bs[i], 0);
        check({tag, "_done"}, dn[i], 0);
        check({tag, "_pass"}, ps[i], 0);
        check({tag, "_err_vec"}, ev[i], 0);
        check({tag, "_err_count"}, ec[i], 0);
    endtask

    // Expected result from the fault table: every vector is visited REPEAT times.
    task automatic model(input int i, output logic [5:0] exp_vec, output int exp_cnt);
        logic [5:0] m;
        logic [1:0] v2;
        int total;
        exp_vec = '0;
        total = 0;
        for (int v = 0; v < 4; v++) begin
            v2 = v[1:0];
            m = faulty_y(mode_r[i], v2[1], v2[0], tbl[i][v2]) ^ truth(v2[1], v2[0]);
            exp_vec |= m;
            total += $countones(m);
        end
        total *= rep[i];
        exp_cnt = (total > maxc[i]) ? maxc[i] : total;
    endtask

    task automatic run_case(input int i, input string tag, input logic [5:0] exp_vec,
                            input int exp_cnt, input bit poke);
        int cyc;
        bit overlap;
        @(negedge clk);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
        cyc = 1;
        overlap = 0;
        check({tag, "_busy_after_start"}, bs[i], 1);
        while (!dn[i] && cyc < 200) begin
            if (bs[i] && dn[i]) overlap = 1;
            if (poke) st[i] = (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        st[i] = 1'b0;
        check({tag, "_latency"}, cyc, 8 * rep[i] + 1);
        check({tag, "_busy_done_overlap"}, overlap, 0);
        check({tag, "_busy_at_done"}, bs[i], 0);
        check({tag, "_pass"}, ps[i], (exp_vec == 6'd0));
        check({tag, "_err_vec"}, ev[i], exp_vec);
        check({tag, "_err_count"}, ec[i], exp_cnt);
        @(negedge clk);
        check({tag, "_done_held"}, dn[i], 1);
        check({tag, "_count_held"}, ec[i], exp_cnt);
    endtask

    initial begin
        logic [5:0] mv;
        int mc;
        int cyc;
        int idx;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            mode_r[i] = 0;
            for (int v = 0; v < 4; v++) tbl[i][v] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) check_reset_outputs(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_case(0, "all_ok", 6'b000000, 0, 0);
        mode_r[0] = 1;
        run_case(0, "xor_stuck0", 6'b010000, 2, 0);
        mode_r[0] = 2;
        run_case(0, "nand_in_and", 6'b000001, 4, 0);
        mode_r[1] = 3;
        run_case(1, "xnor_stuck1_r2", 6'b100000, 4, 1);
        mode_r[2] = 4;
        run_case(2, "invert_sat", 6'b111111, 3, 0);

        // Held start in DONE restarts the run every 8*REPEAT+1 cycles.
        mode_r[0] = 0;
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        cyc = 1;
        check("restart_done_drops", dn[0], 0);
        while (!dn[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        st[0] = 1'b0;
        check("restart_period", cyc, 9);
        check("restart_pass", ps[0], 1);
        @(negedge clk);

        // Reset during the SAMPLE of vector 10 with errors already counted.
        mode_r[0] = 4;
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        for (int k = 1; k < 6; k++) @(negedge clk);
        check("midrun_partial_count", ec[0], 12);
        check("midrun_gate_a", ga[0], 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        mode_r[0] = 0;
        run_case(0, "after_reset", 6'b000000, 0, 0);

        for (int r = 0; r < 9; r++) begin
            idx = $urandom_range(0, 2);
            mode_r[idx] = 5;
            for (int v = 0; v < 4; v++) begin
                tbl[idx][v] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom & 32'h3f);
            end
            if ($urandom_range(0, 4) == 0) begin
                for (int v = 0; v < 4; v++) tbl[idx][v] = '0;
            end
            model(idx, mv, mc);
            run_case(idx, $sformatf("rand%0d_d%0d", r, idx), mv, mc, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
